// File: rtl/top.sv
// Three-colour PRBS7 symbol transmitter: each colour emits a reference stream and a
// copy shaped by a whole-cycle delay plus independent rising/falling edge delays.
module top (
    input  logic clk_x10,
    input  logic g_rst,
    input  logic send_enable_button,
    input  logic send_stop_button,
    input  logic r_whole_delay_button,
    input  logic g_whole_delay_button,
    input  logic b_whole_delay_button,
    input  logic r_rising_delay_button,
    input  logic g_rising_delay_button,
    input  logic b_rising_delay_button,
    input  logic r_falling_delay_button,
    input  logic g_falling_delay_button,
    input  logic b_falling_delay_button,
    output logic slow_rst,
    output logic red_output_ref_p,
    output logic red_output_ref_n,
    output logic green_output_ref_p,
    output logic green_output_ref_n,
    output logic blue_output_ref_p,
    output logic blue_output_ref_n,
    output logic red_output_delay_p,
    output logic red_output_delay_n,
    output logic green_output_delay_p,
    output logic green_output_delay_n,
    output logic blue_output_delay_p,
    output logic blue_output_delay_n,
    output logic led_out_3,
    output logic led_out_2,
    output logic led_out_1,
    output logic led_out_0
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam int NBTN = 11;
    localparam int EN_IDX = 0;
    localparam int STOP_IDX = 1;
    localparam logic [2:0][6:0] SEEDS = {7'h55, 7'h2A, 7'h01};

    state_t            state_reg;
    logic              slow_rst_reg;
    logic [6:0]        slow_cnt_reg;
    logic [3:0]        tc_reg;
    logic [23:0]       hb_cnt_reg;
    logic              hb_led_reg;
    logic [NBTN-1:0]   btn_raw;
    logic [NBTN-1:0]   sync1_reg, sync2_reg, sync3_reg;
    logic [NBTN-1:0]   evt;
    logic              advance;
    logic [2:0]        ref_p_vec, ref_n_vec, dly_p_vec, dly_n_vec, nz_vec;

    // Bit order: enable, stop, whole r/g/b, rising r/g/b, falling r/g/b
    assign btn_raw = {b_falling_delay_button, g_falling_delay_button, r_falling_delay_button,
                      b_rising_delay_button,  g_rising_delay_button,  r_rising_delay_button,
                      b_whole_delay_button,   g_whole_delay_button,   r_whole_delay_button,
                      send_stop_button, send_enable_button};

    always_ff @(posedge clk_x10 or negedge g_rst) begin
        if (!g_rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            sync3_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign evt = sync2_reg & ~sync3_reg & {NBTN{~slow_rst_reg}};

    always_ff @(posedge clk_x10 or negedge g_rst) begin
        if (!g_rst) begin
            slow_rst_reg <= 1'b1;
            slow_cnt_reg <= '0;
        end else if (slow_rst_reg) begin
            if (slow_cnt_reg == 7'd99) begin
                slow_rst_reg <= 1'b0;
            end else begin
                slow_cnt_reg <= slow_cnt_reg + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_x10 or negedge g_rst) begin
        if (!g_rst) begin
            tc_reg     <= '0;
            hb_cnt_reg <= '0;
            hb_led_reg <= 1'b0;
        end else begin
            tc_reg     <= (tc_reg == 4'd9) ? 4'd0 : tc_reg + 4'd1;
            hb_cnt_reg <= hb_cnt_reg + 24'd1;
            if (hb_cnt_reg == '1) begin
                hb_led_reg <= ~hb_led_reg;
            end
        end
    end

    // Stop has priority over enable when both arrive together
    always_ff @(posedge clk_x10 or negedge g_rst) begin
        if (!g_rst) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (evt[EN_IDX] && !evt[STOP_IDX]) state_reg <= SEND;
                SEND:    if (evt[STOP_IDX]) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign advance = (state_reg == SEND) && (tc_reg == 4'd9);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_colour
            logic [6:0]  prbs_reg;
            logic [3:0]  whole_reg;
            logic [2:0]  rise_reg, fall_reg;
            logic        ref_p_reg, ref_n_reg, dly_p_reg, dly_n_reg;
            logic [15:0] sr_reg;
            logic        s_q_reg, pend_reg;
            logic [2:0]  cnt_reg;
            logic        ref_next, s_cur, dly_next, pend_next;
            logic [2:0]  cnt_next, dly_amt;

            assign ref_next = (state_reg == SEND) & prbs_reg[6];

            always_comb begin
                s_cur = (whole_reg == 4'd0) ? ref_p_reg : sr_reg[whole_reg - 4'd1];
            end

            // A new s transition always restarts the edge timer, cancelling any pending edge
            always_comb begin
                dly_next  = dly_p_reg;
                pend_next = pend_reg;
                cnt_next  = cnt_reg;
                dly_amt   = s_cur ? rise_reg : fall_reg;
                if (s_cur != s_q_reg) begin
                    if (dly_amt == 3'd0) begin
                        dly_next  = s_cur;
                        pend_next = 1'b0;
                    end else begin
                        pend_next = 1'b1;
                        cnt_next  = dly_amt - 3'd1;
                    end
                end else if (pend_reg) begin
                    if (cnt_reg == 3'd0) begin
                        dly_next  = s_cur;
                        pend_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
            end

            always_ff @(posedge clk_x10 or negedge g_rst) begin
                if (!g_rst) begin
                    prbs_reg  <= SEEDS[gi];
                    whole_reg <= '0;
                    rise_reg  <= '0;
                    fall_reg  <= '0;
                    ref_p_reg <= 1'b0;
                    ref_n_reg <= 1'b1;
                    dly_p_reg <= 1'b0;
                    dly_n_reg <= 1'b1;
                    sr_reg    <= '0;
                    s_q_reg   <= 1'b0;
                    pend_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    if (advance) begin
                        prbs_reg <= {prbs_reg[5:0], prbs_reg[6] ^ prbs_reg[5]};
                    end
                    if (evt[2 + gi]) whole_reg <= whole_reg + 4'd1;
                    if (evt[5 + gi]) rise_reg  <= rise_reg + 3'd1;
                    if (evt[8 + gi]) fall_reg  <= fall_reg + 3'd1;
                    ref_p_reg <= ref_next;
                    ref_n_reg <= ~ref_next;
                    sr_reg    <= {sr_reg[14:0], ref_p_reg};
                    s_q_reg   <= s_cur;
                    dly_p_reg <= dly_next;
                    dly_n_reg <= ~dly_next;
                    pend_reg  <= pend_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign ref_p_vec[gi] = ref_p_reg;
            assign ref_n_vec[gi] = ref_n_reg;
            assign dly_p_vec[gi] = dly_p_reg;
            assign dly_n_vec[gi] = dly_n_reg;
            assign nz_vec[gi]    = |{whole_reg, rise_reg, fall_reg};
        end
    endgenerate

    assign slow_rst             = slow_rst_reg;
    assign red_output_ref_p     = ref_p_vec[0];
    assign red_output_ref_n     = ref_n_vec[0];
    assign green_output_ref_p   = ref_p_vec[1];
    assign green_output_ref_n   = ref_n_vec[1];
    assign blue_output_ref_p    = ref_p_vec[2];
    assign blue_output_ref_n    = ref_n_vec[2];
    assign red_output_delay_p   = dly_p_vec[0];
    assign red_output_delay_n   = dly_n_vec[0];
    assign green_output_delay_p = dly_p_vec[1];
    assign green_output_delay_n = dly_n_vec[1];
    assign blue_output_delay_p  = dly_p_vec[2];
    assign blue_output_delay_n  = dly_n_vec[2];

    assign led_out_0 = (state_reg == SEND);
    assign led_out_1 = ~slow_rst_reg;
    assign led_out_2 = hb_led_reg;
    assign led_out_3 = |nz_vec;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: slow reset, button events, PRBS reference stream,
// whole/edge delay shaping, stop-priority and mid-transmission reset.
module tb_top;

    logic        clk_x10 = 1'b0;
    logic        g_rst;
    logic [10:0] btn;
    logic        slow_rst;
    logic        red_output_ref_p, red_output_ref_n, green_output_ref_p, green_output_ref_n;
    logic        blue_output_ref_p, blue_output_ref_n;
    logic        red_output_delay_p, red_output_delay_n, green_output_delay_p, green_output_delay_n;
    logic        blue_output_delay_p, blue_output_delay_n;
    logic        led_out_3, led_out_2, led_out_1, led_out_0;

    logic [2:0]  refp, refn, dlyp, dlyn;
    logic [5:0]  pn_xor;
    logic [3:0]  leds;
    logic [3:0]  phase;
    logic [0:20] sym;
    int          n_checks = 0;
    int          n_errors = 0;
    int          hi_cnt;

    always #5 clk_x10 = ~clk_x10;

    top dut (
        .clk_x10(clk_x10), .g_rst(g_rst),
        .send_enable_button(btn[0]), .send_stop_button(btn[1]),
        .r_whole_delay_button(btn[2]), .g_whole_delay_button(btn[3]), .b_whole_delay_button(btn[4]),
        .r_rising_delay_button(btn[5]), .g_rising_delay_button(btn[6]), .b_rising_delay_button(btn[7]),
        .r_falling_delay_button(btn[8]), .g_falling_delay_button(btn[9]), .b_falling_delay_button(btn[10]),
        .slow_rst(slow_rst),
        .red_output_ref_p(red_output_ref_p), .red_output_ref_n(red_output_ref_n),
        .green_output_ref_p(green_output_ref_p), .green_output_ref_n(green_output_ref_n),
        .blue_output_ref_p(blue_output_ref_p), .blue_output_ref_n(blue_output_ref_n),
        .red_output_delay_p(red_output_delay_p), .red_output_delay_n(red_output_delay_n),
        .green_output_delay_p(green_output_delay_p), .green_output_delay_n(green_output_delay_n),
        .blue_output_delay_p(blue_output_delay_p), .blue_output_delay_n(blue_output_delay_n),
        .led_out_3(led_out_3), .led_out_2(led_out_2), .led_out_1(led_out_1), .led_out_0(led_out_0)
    );

    assign refp   = {blue_output_ref_p, green_output_ref_p, red_output_ref_p};
    assign refn   = {blue_output_ref_n, green_output_ref_n, red_output_ref_n};
    assign dlyp   = {blue_output_delay_p, green_output_delay_p, red_output_delay_p};
    assign dlyn   = {blue_output_delay_n, green_output_delay_n, red_output_delay_n};
    assign pn_xor = {refn, dlyn} ^ {refp, dlyp};
    assign leds   = {led_out_3, led_out_2, led_out_1, led_out_0};

    // Symbol-phase tracker: counts edges since reset release, mod 10
    always @(posedge clk_x10 or negedge g_rst) begin
        if (!g_rst) phase <= 4'd0;
        else        phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (3) @(negedge clk_x10);
        btn[idx] = 1'b0;
        repeat (3) @(negedge clk_x10);
    endtask

    task automatic wait_phase(input logic [3:0] p);
        for (int i = 0; i < 20; i++) begin
            if (phase == p) break;
            @(negedge clk_x10);
        end
    endtask

    // Expected red ref_p for the first transmission run (sample j after SEND entry)
    function automatic logic exp_ref1(input int j);
        if (j < 1)    return 1'b0;
        if (j <= 158) return sym[(j - 1) / 10];
        if (j <= 200) return 1'b0;
        return sym[15 + (j - 201) / 10];
    endfunction

    initial begin
        sym   = 21'b000000100000110000101;
        g_rst = 1'b0;
        btn   = '0;
        repeat (3) @(negedge clk_x10);
        chk("rst_p", {26'd0, refp, dlyp}, 32'h0);
        chk("rst_n", {26'd0, refn, dlyn}, 32'h3f);
        chk("rst_slow", {31'd0, slow_rst}, 32'h1);
        chk("rst_leds", {28'd0, leds}, 32'h0);

        // Slow reset window; an enable press inside it must be ignored
        g_rst = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk_x10);
            if (k == 10) btn[0] = 1'b1;
            if (k == 14) btn[0] = 1'b0;
            if (k == 50) chk("slow_p_quiet", {26'd0, refp, dlyp}, 32'h0);
            if (k == 99) chk("slow_still_high", {31'd0, slow_rst}, 32'h1);
            if (k == 100) chk("slow_fell", {31'd0, slow_rst}, 32'h0);
        end
        repeat (10) @(negedge clk_x10);
        chk("ignored_in_slow", {31'd0, led_out_0}, 32'h0);
        chk("led1_after_slow", {31'd0, led_out_1}, 32'h1);
        chk("idle_n", {26'd0, refn, dlyn}, 32'h3f);

        // Whole-delay wrap: 16 presses return W to 0
        press(2);
        chk("led3_w1", {31'd0, led_out_3}, 32'h1);
        for (int i = 0; i < 15; i++) press(2);
        chk("led3_wrap", {31'd0, led_out_3}, 32'h0);
        for (int i = 0; i < 3; i++) press(2);
        chk("led3_w3", {31'd0, led_out_3}, 32'h1);

        // Run 1: red W=3; enable aligned so SEND starts at a symbol boundary
        wait_phase(4'd7);
        btn[0] = 1'b1;
        repeat (3) @(negedge clk_x10);
        chk("send_entry", {31'd0, led_out_0}, 32'h1);
        for (int j = 1; j <= 240; j++) begin
            @(negedge clk_x10);
            chk($sformatf("ref_r j=%0d", j), {31'd0, red_output_ref_p}, {31'd0, exp_ref1(j)});
            chk($sformatf("dly_r_w3 j=%0d", j), {31'd0, red_output_delay_p}, {31'd0, exp_ref1(j - 4)});
            chk($sformatf("pn_inv j=%0d", j), {26'd0, pn_xor}, 32'h3f);
            if (j == 5) begin
                chk("ref_g_s0", {31'd0, green_output_ref_p}, 32'h0);
                chk("ref_b_s0", {31'd0, blue_output_ref_p}, 32'h1);
            end
            if (j == 11) chk("dly_g_11", {31'd0, green_output_delay_p}, 32'h0);
            if (j == 12) chk("dly_g_12", {31'd0, green_output_delay_p}, 32'h1);
            if (j == 15) chk("ref_g_s1", {31'd0, green_output_ref_p}, 32'h1);
            if (j == 115) chk("enable_in_send_noop", {31'd0, led_out_0}, 32'h1);
            if (j == 157) chk("send_before_stop", {31'd0, led_out_0}, 32'h1);
            if (j == 158) chk("stop_wins", {31'd0, led_out_0}, 32'h0);
            if (j == 180) chk("stop_in_idle_noop", {31'd0, led_out_0}, 32'h0);
            if (j == 200) chk("reenter_send", {31'd0, led_out_0}, 32'h1);
            if (j == 100) btn[0] = 1'b0;
            if (j == 110) btn[0] = 1'b1;
            if (j == 150) btn[0] = 1'b0;
            if (j == 155) btn[1:0] = 2'b11;
            if (j == 160) btn[1:0] = 2'b00;
            if (j == 170) btn[1] = 1'b1;
            if (j == 175) btn[1] = 1'b0;
            if (j == 197) btn[0] = 1'b1;
        end
        btn[0] = 1'b0;

        // Reset in the middle of transmission
        @(negedge clk_x10);
        g_rst = 1'b0;
        #1;
        chk("midrst_p", {26'd0, refp, dlyp}, 32'h0);
        chk("midrst_n", {26'd0, refn, dlyn}, 32'h3f);
        chk("midrst_slow", {31'd0, slow_rst}, 32'h1);
        chk("midrst_leds", {28'd0, leds}, 32'h0);
        repeat (3) @(negedge clk_x10);
        g_rst = 1'b1;
        repeat (110) @(negedge clk_x10);
        chk("post_rst_slow", {31'd0, slow_rst}, 32'h0);
        chk("post_rst_idle", {31'd0, led_out_0}, 32'h0);
        chk("post_rst_ref", {31'd0, red_output_ref_p}, 32'h0);
        chk("post_rst_led3", {31'd0, led_out_3}, 32'h0);

        // Run 2: red W=0, R=2, F=5; the 10-cycle pulse at s6 becomes 13 cycles
        press(5);
        press(5);
        for (int i = 0; i < 5; i++) press(8);
        chk("led3_rf", {31'd0, led_out_3}, 32'h1);
        wait_phase(4'd7);
        btn[0] = 1'b1;
        repeat (3) @(negedge clk_x10);
        chk("send_entry2", {31'd0, led_out_0}, 32'h1);
        hi_cnt = 0;
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk_x10);
            chk($sformatf("ref_r2 j=%0d", j), {31'd0, red_output_ref_p}, {31'd0, sym[(j - 1) / 10]});
            if (red_output_delay_p === 1'b1) hi_cnt++;
            if (j == 63) chk("rise_not_yet", {31'd0, red_output_delay_p}, 32'h0);
            if (j == 64) chk("rise_at_r2", {31'd0, red_output_delay_p}, 32'h1);
            if (j == 76) chk("fall_not_yet", {31'd0, red_output_delay_p}, 32'h1);
            if (j == 77) chk("fall_at_f5", {31'd0, red_output_delay_p}, 32'h0);
        end
        chk("pulse_width_13", hi_cnt, 32'd13);
        btn[0] = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 clk_x10  in  1  sole clock; symbol rate is clk_x10/10; all logic on rising edge.
REQ-002 g_rst  in  1  asynchronous, active-low reset.
REQ-003 slow_rst  out  1  internal slow-domain reset, exposed for test.
REQ-004 send_enable_button, send_stop_button  in  1 each  start/stop transmission.
REQ-005 r/g/b_whole_delay_button  in  1 each  increment per-colour whole delay W.
REQ-006 r/g/b_rising_delay_button  in  1 each  increment per-colour rising-edge delay R.
REQ-007 r/g/b_falling_delay_button  in  1 each  increment per-colour falling-edge delay F.
REQ-008 red/green/blue_output_ref_p/_n  out  1 each  undelayed symbol stream, differential.
REQ-009 red/green/blue_output_delay_p/_n  out  1 each  delay-shaped copy of the ref stream, differential.
REQ-010 led_out_3..led_out_0  out  1 each  status LEDs.

Function
REQ-011 Every _n output SHALL be the registered inverse of its _p output.
REQ-012 Mod-10 counter tc (0..9) SHALL run continuously; symbol boundary at tc=0.
REQ-013 slow_rst SHALL be 1 during reset and for 100 clk_x10 cycles after g_rst rises, then 0 until the next reset.
REQ-014 Each button SHALL pass a 2-flop synchronizer plus rising-edge detector; one press = one event regardless of hold length; no debounce; events ignored while slow_rst=1.
REQ-015 FSM states IDLE and SEND; IDLE->SEND on enable event; SEND->IDLE on stop event; stop wins when both occur in the same cycle; enable in SEND and stop in IDLE are no-ops.
REQ-016 Per-colour PRBS7 (x^7+x^6+1), seeds R=7'h01, G=7'h2A, B=7'h55; advance one step when tc=9 in SEND only; hold in IDLE.
REQ-017 Symbol bit = PRBS MSB, held constant for the 10 cycles from tc=0 to tc=9.
REQ-018 ref_p SHALL equal the symbol bit registered once (1-cycle latency) in SEND, and 0 in IDLE.
REQ-019 W is 4 bits (0..15); R and F are 3 bits (0..7); each increments by 1 per event and wraps (W 15->0, R/F 7->0).
REQ-020 s = ref_p delayed by exactly W further clk_x10 cycles, using a 16-deep shift register.
REQ-021 delay_p SHALL rise R cycles after s rises and fall F cycles after s falls.
REQ-022 In REQ-021, if s changes again before the pending delay_p edge, that pending edge is cancelled and delay_p follows the new s transition.
REQ-023 With R=F=0, delay_p SHALL equal s registered once.
REQ-024 Delay register changes SHALL take effect on the next cycle; the shift register is not flushed.
REQ-025 led_out_0=1 in SEND; led_out_1=~slow_rst; led_out_2 toggles every 2^24 cycles; led_out_3=1 when any W/R/F is nonzero.

Reset
REQ-026 On g_rst=0, asynchronously:
- FSM -> IDLE; tc=0; W=R=F=0; PRBS registers to their seeds; shift registers cleared.
- all _p outputs 0, all _n outputs 1; slow_rst=1; all LEDs 0.
REQ-027 Reset mid-transmission SHALL abort immediately; after reset release the state is IDLE, so a new enable event is required.

Verification
REQ-028 Release g_rst -> slow_rst falls exactly 100 cycles later; all ref/delay _p outputs stay 0 and _n outputs 1.
REQ-029 Enable press held 20 ms -> single IDLE->SEND transition, led_out_0=1; red ref_p shows seed-01 PRBS7 sequence at 10 cycles/bit.
REQ-030 W=3, R=F=0 -> each delay_p edge occurs 4 cycles after the matching ref_p edge.
REQ-031 W=0, R=2, F=5 -> delay_p high pulse = ref_p high pulse -2+5 cycles; 10-cycle pulse becomes 13 cycles.
REQ-032 16 whole-delay presses -> W wraps to 0 and led_out_3 returns to 0 if R=F=0.
REQ-033 Enable and stop events in the same cycle while in SEND -> IDLE; ref_p=0 next cycle and PRBS frozen.
